// File: rtl/addsub_accum.sv
// Add/subtract accumulator with a one-entry valid/ready output register.
// Optional clamping to signed max/min on overflow.
module addsub_accum #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             neg,
    output logic             sticky_ovf
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;

    logic             accept;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             c_msb;
    logic             raw_ovf;

    assign out_valid  = (state_q == FULL);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign acc        = acc_q;
    assign cout       = cout_q;
    assign overflow   = ovf_q;
    assign sticky_ovf = sticky_q;
    assign zero       = (acc_q == '0);
    assign neg        = acc_q[WIDTH-1];

    // SUB is acc + ~y + 1, so both ops share one adder
    assign cin     = (op == OP_SUB);
    assign y       = cin ? ~operand : operand;
    assign sum     = {1'b0, acc_q} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign c_msb   = acc_q[WIDTH-1] ^ y[WIDTH-1] ^ sum[WIDTH-1];
    assign raw_ovf = c_msb ^ sum[WIDTH];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        if (accept) begin
            state_d = FULL;
            unique case (op)
                OP_LOAD: begin
                    acc_d    = operand;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                end
                OP_ADD, OP_SUB: begin
                    cout_d   = sum[WIDTH];
                    ovf_d    = raw_ovf;
                    sticky_d = sticky_q | raw_ovf;
                    if (SATURATE && raw_ovf)
                        acc_d = acc_q[WIDTH-1] ? SMIN : SMAX;
                    else
                        acc_d = sum[WIDTH-1:0];
                end
                OP_CLEAR: begin
                    acc_d    = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                end
                default: ;
            endcase
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            acc_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_addsub_accum.sv
// Directed bench for addsub_accum: wrap and saturating instances
// share one stimulus stream.
module tb_addsub_accum;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] operand;
    logic         out_ready;

    logic         in_ready, out_valid, cout, overflow, zero, neg, sticky_ovf;
    logic [W-1:0] acc;
    logic         s_in_ready, s_out_valid, s_cout, s_overflow;
    logic         s_zero, s_neg, s_sticky;
    logic [W-1:0] s_acc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_accum #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand(operand), .out_valid(out_valid),
        .out_ready(out_ready), .acc(acc), .cout(cout),
        .overflow(overflow), .zero(zero), .neg(neg),
        .sticky_ovf(sticky_ovf)
    );

    addsub_accum #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .operand(operand), .out_valid(s_out_valid),
        .out_ready(out_ready), .acc(s_acc), .cout(s_cout),
        .overflow(s_overflow), .zero(s_zero), .neg(s_neg),
        .sticky_ovf(s_sticky)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive at negedge, accept on posedge, leave sampled at next negedge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] v);
        in_valid = 1'b1;
        op       = o;
        operand  = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 2'b00;
        operand = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_acc", acc, 0);
        check("rst_zero", W'(zero), 1);
        check("rst_neg", W'(neg), 0);
        check("rst_cout", W'(cout), 0);
        check("rst_ovf", W'(overflow), 0);
        check("rst_sticky", W'(sticky_ovf), 0);
        check("rst_ovalid", W'(out_valid), 0);
        check("rst_iready", W'(in_ready), 1);

        issue(2'b00, 32'd11);
        check("load11_acc", acc, 32'd11);
        check("load11_ovalid", W'(out_valid), 1);
        issue(2'b01, 32'd2999999);
        check("add_acc", acc, 32'd3000010);
        check("add_cout", W'(cout), 0);
        check("add_ovf", W'(overflow), 0);
        check("add_zero", W'(zero), 0);
        check("add_neg", W'(neg), 0);
        @(negedge clk);
        check("drain_ovalid", W'(out_valid), 0);

        issue(2'b00, 32'h7FFF_FFFF);
        issue(2'b01, 32'd1);
        check("povf_acc", acc, 32'h8000_0000);
        check("povf_ovf", W'(overflow), 1);
        check("povf_cout", W'(cout), 0);
        check("povf_neg", W'(neg), 1);
        check("povf_sticky", W'(sticky_ovf), 1);
        check("sat_povf_acc", s_acc, 32'h7FFF_FFFF);
        check("sat_povf_ovf", W'(s_overflow), 1);
        check("sat_povf_sticky", W'(s_sticky), 1);

        issue(2'b00, 32'h8000_0000);
        check("load_clr_sticky", W'(sticky_ovf), 0);
        issue(2'b10, 32'd1);
        check("novf_acc", acc, 32'h7FFF_FFFF);
        check("novf_ovf", W'(overflow), 1);
        check("novf_cout", W'(cout), 1);
        check("sat_novf_acc", s_acc, 32'h8000_0000);
        check("sat_novf_cout", W'(s_cout), 1);
        issue(2'b11, 32'h1234_5678);
        check("clr_acc", acc, 0);
        check("clr_zero", W'(zero), 1);
        check("clr_sticky", W'(sticky_ovf), 0);
        check("clr_ovf", W'(overflow), 0);

        issue(2'b00, 32'd0);
        issue(2'b10, 32'd1);
        check("sub1_acc", acc, 32'hFFFF_FFFF);
        check("sub1_cout", W'(cout), 0);
        check("sub1_ovf", W'(overflow), 0);
        check("sub1_neg", W'(neg), 1);
        issue(2'b00, -32'sd323);
        issue(2'b10, -32'sd77771);
        check("subneg_acc", acc, 32'd77448);
        check("subneg_cout", W'(cout), 1);
        check("subneg_ovf", W'(overflow), 0);

        issue(2'b00, 32'd5);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b01;
        operand   = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_iready", W'(in_ready), 0);
            check("stall_acc", acc, 32'd5);
            check("stall_ovalid", W'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1 check("unstall_iready", W'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("unstall_acc", acc, 32'd8);
        check("unstall_ovalid", W'(out_valid), 1);

        issue(2'b00, 32'h7FFF_FFFF);
        issue(2'b01, 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b01;
        operand   = 32'd1;
        @(negedge clk);
        check("pre_rst_sticky", W'(sticky_ovf), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("frst_ovalid", W'(out_valid), 0);
        check("frst_acc", acc, 0);
        check("frst_sticky", W'(sticky_ovf), 0);
        check("frst_iready", W'(in_ready), 1);
        check("frst_sat_acc", s_acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
